fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage of the RISC-V core; owns the PC and drives a request/response handshake to instruction memory.
- Latches the returned instruction and presents it to decode.
- Exposes inst[31:7] directly as the 25-bit immediate-field bus consumed by the immediate generator.
- Accepts redirects (branch/jump targets) from execute and flags fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- TIMEOUT, 16, max cycles spent in WAIT before a fetch fault is raised; range 1..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address; always equals the current PC.
- imem_ready  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  instruction word.
- redirect_valid  input  1  execute requests a PC change.
- redirect_pc  input  32  new PC target.
- dec_ready  input  1  decode consumes the presented instruction this cycle.
- inst_valid  output  1  inst/inst_pc/imm_field are valid.
- inst_pc  output  32  PC of the presented instruction.
- inst  output  32  latched instruction word.
- imm_field  output  25  inst[31:7], routed to the immediate generator.
- fetch_fault  output  1  sticky fault flag.

Behaviour:
- Reset, one clock and reset only: clk rising edge, rst synchronous active-high.
- Reset values: pc=RESET_PC; state=IDLE; imem_req=0; inst_valid=0; inst=32'h0000_0013 (NOP), so imm_field=25'h0; inst_pc=RESET_PC; fetch_fault=0; drop=0; timeout counter=0.
- States: IDLE, REQ, WAIT, VALID, FAULT.
- IDLE: outputs quiet; next cycle goes to REQ.
- REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_ready go to WAIT and clear the counter.
  - Otherwise hold; imem_req and imem_addr stay stable until accepted.
- WAIT:
  - imem_req=0; counter increments each cycle.
  - On imem_rvalid with drop=0: inst<=imem_rdata, inst_pc<=pc, go to VALID.
  - On imem_rvalid with drop=1: discard the data, clear drop, go to REQ.
- VALID:
  - inst_valid=1; outputs stable while dec_ready=0.
  - On dec_ready: pc<=pc+4 (mod 2^32 wrap), go to REQ.
  - inst_valid is low in the following cycle.
- Minimum latency: request accepted at cycle N, rvalid at N+1, inst_valid at N+2.
- Redirect (redirect_valid=1, redirect_pc[1:0]==0); in every case redirect takes priority over dec_ready and over pc+4:
  - In REQ: pc<=redirect_pc, stay in REQ. If imem_ready is high in the same cycle, that request is already accepted: go to WAIT with drop=1.
  - In WAIT with imem_rvalid=0: pc<=redirect_pc, drop<=1, stay in WAIT. The counter keeps running.
  - In WAIT with imem_rvalid=1: discard the data, pc<=redirect_pc, go to REQ, drop=0.
  - In VALID: pc<=redirect_pc, go to REQ; inst_valid drops the next cycle.
  - In IDLE: pc<=redirect_pc.
- Misaligned redirect (redirect_pc[1:0]!=0) in any state except FAULT: fetch_fault<=1, go to FAULT. pc is not updated.
- Timeout: counter reaches TIMEOUT in WAIT without rvalid -> fetch_fault<=1, go to FAULT.
- FAULT: imem_req=0, inst_valid=0; all inputs ignored; exit only through rst.
- imem_rvalid outside WAIT is ignored.
- imm_field is a pure slice of the inst register, so it changes in the same cycle as inst.
- rst asserted mid-fetch: next cycle is the full reset state. A late response arrives in IDLE/REQ and is ignored. A subsequent WAIT only accepts responses that follow a new handshake.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum (IDLE, REQ, WAIT, VALID, FAULT).
  - NOP_INST = 32'h0000_0013.
  - PC_STEP = 4.
- Sub-module fetch_timeout_ctr: parameterized by TIMEOUT; inputs clk, rst, clear, enable; output expired. Enable is asserted only in WAIT.

Test Plan:
- Sequential fetch:
  - Stimulus: reset with RESET_PC=0; memory ready and responding in 1 cycle with 32'hFFF00093; dec_ready=1.
  - Response: imem_addr sequence 0,4,8. inst_valid first high 3 cycles after reset release; imm_field=25'h1FFE001; inst_pc=0.
- Decode backpressure:
  - Stimulus: dec_ready=0 for 5 cycles in VALID.
  - Response: inst, inst_pc, imm_field stable; no new imem_req; pc advances by 4 only after dec_ready=1.
- Redirect in WAIT:
  - Stimulus: redirect_pc=32'h100 while a fetch at 0x8 is outstanding; rvalid 2 cycles later.
  - Response: that data is discarded, inst_valid stays 0; the next request has imem_addr=0x100.
- Simultaneous redirect and dec_ready in VALID:
  - Stimulus: both asserted with redirect_pc=32'h40.
  - Response: next imem_addr=0x40, not pc+4.
- Faults:
  - Stimulus: redirect_pc=32'h102.
  - Response: fetch_fault=1 next cycle; no further imem_req until rst.
  - Stimulus, separately: withhold rvalid for TIMEOUT=16 cycles.
  - Response: fetch_fault=1.
- Reset mid-fetch:
  - Stimulus: rst for one cycle while in WAIT; stale rvalid arrives in IDLE.
  - Response: ignored; inst=32'h13, pc=RESET_PC; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned IMM_W = 25;
    localparam int unsigned CNT_W = 8;

    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        VALID,
        FAULT
    } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts cycles spent waiting on instruction memory and flags when the limit is hit.
module fetch_timeout_ctr
    import fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturate so a stuck enable can never wrap back under the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High in the cycle whose increment would make the count reach TIMEOUT.
    assign expired = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, handshakes with imem, presents instructions to decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [XLEN-1:0]       imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [XLEN-1:0]       imem_rdata,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    input  logic                  dec_ready,
    output logic                  inst_valid,
    output logic [XLEN-1:0]       inst_pc,
    output logic [XLEN-1:0]       inst,
    output logic [IMM_W-1:0]      imm_field,
    output logic                  fetch_fault
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            drop_q, drop_d;
    logic            fault_q, fault_d;
    logic            imem_req_q;
    logic            inst_valid_q;
    logic            ctr_clear;
    logic            ctr_enable;
    logic            ctr_expired;
    logic            redir_ok;
    logic            redir_bad;

    assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (ctr_clear),
        .enable  (ctr_enable),
        .expired (ctr_expired)
    );

    // Next-state: redirect beats dec_ready and pc+4; misaligned redirect overrides everything.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        drop_d     = drop_q;
        fault_d    = fault_q;
        ctr_clear  = 1'b0;
        ctr_enable = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redir_ok) pc_d = redirect_pc;
            end
            REQ: begin
                if (redir_ok) pc_d = redirect_pc;
                if (imem_ready) begin
                    state_d   = WAIT;
                    ctr_clear = 1'b1;
                    drop_d    = redir_ok;
                end
            end
            WAIT: begin
                ctr_enable = 1'b1;
                if (imem_rvalid) begin
                    if (redir_ok) begin
                        pc_d    = redirect_pc;
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        inst_d    = imem_rdata;
                        inst_pc_d = pc_q;
                        state_d   = VALID;
                    end
                end else begin
                    if (redir_ok) begin
                        pc_d   = redirect_pc;
                        drop_d = 1'b1;
                    end
                    if (ctr_expired) begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end
                end
            end
            VALID: begin
                if (redir_ok) begin
                    pc_d    = redirect_pc;
                    state_d = REQ;
                end else if (dec_ready) begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = REQ;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FAULT;
                fault_d = 1'b1;
            end
        endcase

        if (redir_bad && (state_q != FAULT)) begin
            pc_d      = pc_q;
            inst_d    = inst_q;
            inst_pc_d = inst_pc_q;
            fault_d   = 1'b1;
            state_d   = FAULT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= NOP_INST;
            inst_pc_q    <= RESET_PC;
            drop_q       <= 1'b0;
            fault_q      <= 1'b0;
            imem_req_q   <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            drop_q       <= drop_d;
            fault_q      <= fault_d;
            imem_req_q   <= (state_d == REQ);
            inst_valid_q <= (state_d == VALID);
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign inst_valid  = inst_valid_q;
    assign inst_pc     = inst_pc_q;
    assign inst        = inst_q;
    assign imm_field   = inst_q[31:7];
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: one task per scenario, expected values computed by hand.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_ready;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst;
    logic [24:0] imm_field;
    logic        fetch_fault;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_ready      (dec_ready),
        .inst_valid     (inst_valid),
        .inst_pc        (inst_pc),
        .inst           (inst),
        .imm_field      (imm_field),
        .fetch_fault    (fetch_fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec_ready      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        n_cmp++;
        if ({imem_req, inst_valid, fetch_fault} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got req/valid/fault=%b required 000", {imem_req, inst_valid, fetch_fault});
        end
        n_cmp++;
        if ({inst, imm_field} !== {32'h0000_0013, 25'h0}) begin
            n_fail++;
            $display("FAIL reset_inst: got inst=%h imm=%h required 00000013/0000000", inst, imm_field);
        end
        n_cmp++;
        if ({imem_addr, inst_pc} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_pc: got addr=%h inst_pc=%h required 0/0", imem_addr, inst_pc);
        end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        do_reset();
        imem_ready  = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hFFF0_0093;
        dec_ready   = 1'b1;
        tick();
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL seq_req0: got req=%b addr=%h required 1/00000000", imem_req, imem_addr);
        end
        tick();
        n_cmp++;
        if ({imem_req, inst_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL seq_wait: got req/valid=%b required 00", {imem_req, inst_valid});
        end
        tick();
        n_cmp++;
        if ({inst_valid, inst_pc, imm_field} !== {1'b1, 32'h0, 25'h1FFE001}) begin
            n_fail++;
            $display("FAIL seq_valid0: got valid=%b pc=%h imm=%h required 1/00000000/1ffe001", inst_valid, inst_pc, imm_field);
        end
        tick();
        n_cmp++;
        if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h4, 1'b0}) begin
            n_fail++;
            $display("FAIL seq_req4: got req=%b addr=%h valid=%b required 1/00000004/0", imem_req, imem_addr, inst_valid);
        end
        tick();
        tick();
        n_cmp++;
        if ({inst_valid, inst_pc} !== {1'b1, 32'h4}) begin
            n_fail++;
            $display("FAIL seq_valid4: got valid=%b pc=%h required 1/00000004", inst_valid, inst_pc);
        end
        tick();
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
            n_fail++;
            $display("FAIL seq_req8: got req=%b addr=%h required 1/00000008", imem_req, imem_addr);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        imem_ready  = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h00A0_0513;
        dec_ready   = 1'b0;
        tick();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({inst_valid, imem_req, imem_addr, inst_pc, inst, imm_field} !==
                {1'b1, 1'b0, 32'h0, 32'h0, 32'h00A0_0513, 25'h001400A}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%b req=%b addr=%h pc=%h inst=%h imm=%h required 1/0/0/0/00a00513/001400a",
                         i, inst_valid, imem_req, imem_addr, inst_pc, inst, imm_field);
            end
        end
        dec_ready = 1'b1;
        tick();
        n_cmp++;
        if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h4, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_release: got req=%b addr=%h valid=%b required 1/00000004/0", imem_req, imem_addr, inst_valid);
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        imem_ready  = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0093;
        dec_ready   = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        imem_rvalid = 1'b0;
        tick();
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
            n_fail++;
            $display("FAIL rw_req8: got req=%b addr=%h required 1/00000008", imem_req, imem_addr);
        end
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        n_cmp++;
        if ({imem_req, imem_addr, inst_valid, inst} !== {1'b1, 32'h100, 1'b0, 32'h0000_0093}) begin
            n_fail++;
            $display("FAIL rw_drop: got req=%b addr=%h valid=%b inst=%h required 1/00000100/0/00000093",
                     imem_req, imem_addr, inst_valid, inst);
        end
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0010_0113;
        tick();
        n_cmp++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h100, 32'h0010_0113}) begin
            n_fail++;
            $display("FAIL rw_refetch: got valid=%b pc=%h inst=%h required 1/00000100/00100113", inst_valid, inst_pc, inst);
        end
    endtask

    task automatic test_redirect_vs_dec();
        do_reset();
        imem_ready  = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0093;
        dec_ready   = 1'b0;
        tick();
        tick();
        tick();
        dec_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        n_cmp++;
        if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h40, 1'b0}) begin
            n_fail++;
            $display("FAIL rv_priority: got req=%b addr=%h valid=%b required 1/00000040/0", imem_req, imem_addr, inst_valid);
        end
    endtask

    task automatic test_fault_misaligned();
        do_reset();
        imem_ready = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        n_cmp++;
        if ({fetch_fault, imem_req, imem_addr} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL fm_raise: got fault=%b req=%b addr=%h required 1/0/00000000", fetch_fault, imem_req, imem_addr);
        end
        redirect_pc = 32'h200;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b1;
        dec_ready   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({fetch_fault, imem_req, inst_valid, imem_addr} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
                n_fail++;
                $display("FAIL fm_sticky[%0d]: got fault=%b req=%b valid=%b addr=%h required 1/0/0/00000000",
                         i, fetch_fault, imem_req, inst_valid, imem_addr);
            end
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        n_cmp++;
        if (fetch_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL to_cleared: got fault=%b required 0", fetch_fault);
        end
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 15; i++) tick();
        n_cmp++;
        if (fetch_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL to_early: got fault=%b after 15 wait cycles required 0", fetch_fault);
        end
        tick();
        n_cmp++;
        if ({fetch_fault, imem_req} !== 2'b10) begin
            n_fail++;
            $display("FAIL to_expire: got fault/req=%b after 16 wait cycles required 10", {fetch_fault, imem_req});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        dec_ready   = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0093;
        n_cmp++;
        if ({imem_req, imem_addr, inst, fetch_fault} !== {1'b0, 32'h0, 32'h0000_0013, 1'b0}) begin
            n_fail++;
            $display("FAIL rm_state: got req=%b addr=%h inst=%h fault=%b required 0/00000000/00000013/0",
                     imem_req, imem_addr, inst, fetch_fault);
        end
        tick();
        tick();
        n_cmp++;
        if ({imem_req, imem_addr, inst_valid, inst} !== {1'b1, 32'h0, 1'b0, 32'h0000_0013}) begin
            n_fail++;
            $display("FAIL rm_stale: got req=%b addr=%h valid=%b inst=%h required 1/00000000/0/00000013",
                     imem_req, imem_addr, inst_valid, inst);
        end
        imem_rvalid = 1'b0;
        imem_ready  = 1'b1;
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        tick();
        n_cmp++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h0, 32'h0050_0093}) begin
            n_fail++;
            $display("FAIL rm_restart: got valid=%b pc=%h inst=%h required 1/00000000/00500093", inst_valid, inst_pc, inst);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_vs_dec();
        test_fault_misaligned();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
